// File: rtl/integrate_dump.sv
// integrate_dump
//   Integrate-and-dump stage that follows the registered signed adder. It sums
//   N accepted samples into a saturating accumulator. After the N-th sample it
//   presents the block total on o_data with a one-cycle o_valid strobe, then
//   starts a new block with the next sample.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset, highest priority
//   i_ce     sample valid; i_data is accepted on every rising edge with i_ce=1
//   i_data   signed input sample (IWIDTH)
//   i_clr    synchronous block abort; discards the partial block, wins over i_ce
//   o_valid  one-cycle strobe: o_data/o_ovf hold a new block total
//   o_data   signed saturated block total (OWIDTH), held between strobes
//   o_ovf    set with o_valid if any step of that block saturated
//   o_cnt    samples accepted into the current block (0..N-1)
//   o_state  debug view of the FSM (0 = IDLE, 1 = ACC)
//
// Handshake: the input side is valid-only. i_ce qualifies i_data on each rising
// edge and there is no ready, because a sample is accepted on every cycle.
// The output side is also valid-only. o_valid pulses for exactly one cycle per
// block and the downstream stage must capture o_data on that cycle or later.
// o_data keeps its value until the next strobe.

module integrate_dump #(
  parameter int IWIDTH = 17,
  parameter int N      = 8,
  parameter int OWIDTH = 20,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic [IWIDTH-1:0] i_data,
  input  logic              i_clr,
  output logic              o_valid,
  output logic [OWIDTH-1:0] o_data,
  output logic              o_ovf,
  output logic [CW-1:0]     o_cnt,
  output logic              o_state
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [CW-1:0]     LAST  = CW'(N - 1);
  localparam logic [OWIDTH-1:0] S_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic [OWIDTH-1:0] S_MIN = {1'b1, {(OWIDTH-1){1'b0}}};

  state_t              state;
  logic [OWIDTH-1:0]   acc;
  logic [CW-1:0]       cnt;
  logic                sticky;

  // The sum uses one guard bit. acc is 0 in IDLE, so the same adder also
  // gives sat(i_data) for the first sample of a block.
  logic [OWIDTH:0]     sum;
  logic                sat_hit;
  logic [OWIDTH-1:0]   sat_val;

  always_comb begin
    sum     = {acc[OWIDTH-1], acc}
            + {{(OWIDTH + 1 - IWIDTH){i_data[IWIDTH-1]}}, i_data};
    // The guard bit differs from the top result bit only when the true sum
    // falls outside the OWIDTH range.
    sat_hit = sum[OWIDTH] ^ sum[OWIDTH-1];
    sat_val = sum[OWIDTH-1:0];
    if (sat_hit) begin
      sat_val = sum[OWIDTH] ? S_MIN : S_MAX;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clr) begin
        // Discard the partial block. o_data and o_ovf keep the last total.
        state  <= IDLE;
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end else if (i_ce) begin
        case (state)
          IDLE: begin
            acc    <= sat_val;
            sticky <= sat_hit;
            cnt    <= CW'(1);
            state  <= ACC;
          end
          ACC: begin
            if (cnt == LAST) begin
              o_data  <= sat_val;
              o_valid <= 1'b1;
              o_ovf   <= sticky | sat_hit;
              acc     <= '0;
              cnt     <= '0;
              sticky  <= 1'b0;
              state   <= IDLE;
            end else begin
              acc    <= sat_val;
              sticky <= sticky | sat_hit;
              cnt    <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_cnt   = cnt;
  assign o_state = state;

endmodule

// File: doc/integrate_dump.md
Name: integrate_dump

Overview:
- Downstream consumer of the registered signed adder's sum output.
- Integrates N consecutive valid sum samples, then dumps the block total as a single registered output with a one-cycle valid strobe; accumulation restarts on the next sample.
- The accumulator saturates at the output width, with a per-block overflow flag.
- Sits between the adder and the decimated datapath; the output rate is the input rate divided by N.

Parameters:
- IWIDTH, 17, width of signed input sample (adder output width for 16-bit operands).
- N, 8, samples per dump block; N >= 2.
- OWIDTH, 20, width of signed output total; OWIDTH >= IWIDTH.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_ce  input  1  input sample valid; a sample is accepted on every rising edge with i_ce=1.
- i_data  input  IWIDTH  signed input sample (adder sum).
- i_clr  input  1  synchronous block abort: discard the partial block and restart the count.
- o_valid  output  1  one-cycle strobe, high when o_data holds a new block total.
- o_data  output  OWIDTH  signed block total, saturated to the OWIDTH range.
- o_ovf  output  1  high with o_valid if any saturation occurred in that block.
- o_cnt  output  clog2(N)  number of samples accepted into the current block (0..N-1).

Behaviour:
- Clock and reset:
  - Single clock, i_clk. i_reset is synchronous and active-high.
  - Reset clears acc, cnt, o_data, o_valid, o_ovf and the sticky flag to 0; state returns to IDLE.
  - i_reset has priority over every other input.
- States:
  - IDLE: cnt=0, acc=0. First i_ce: acc<=sat(i_data), cnt<=1, go to ACC.
  - ACC: on i_ce with cnt<N-1: acc<=sat(acc+i_data), cnt<=cnt+1.
  - ACC, dump: on i_ce with cnt==N-1: o_data<=sat(acc+i_data), o_valid<=1, o_ovf<=sticky|this_sat, acc<=0, cnt<=0, sticky<=0, go to IDLE.
- Latency and output timing:
  - o_valid rises on the edge that accepts the N-th sample; o_data is visible the following cycle (1-cycle latency from the last sample).
  - o_valid is a single-cycle pulse, deasserted on every other cycle.
  - o_data and o_ovf hold their last values between strobes.
- Gaps: i_ce=0 leaves acc and cnt unchanged. Gaps inside a block are legal and do not affect the result.
- Back-to-back blocks: after a dump, the next sample accepted (even on the very next cycle) is sample 1 of a new block. No samples are dropped; the dump cycle and the first sample of the next block never overlap.
- Arithmetic:
  - Sum formed at OWIDTH+1 bits with i_data sign-extended.
  - sat() clamps to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
  - Any clamp sets the sticky flag for the current block.
  - Saturation is applied at every step, not only at the dump.
- i_clr:
  - Clears acc, cnt and sticky and returns to IDLE; o_data, o_ovf and o_valid pulse semantics are unaffected.
  - Asserted together with i_ce, i_clr wins: the sample is discarded and no dump occurs.
- o_cnt reflects the registered cnt.
- Reset mid-block: the partial block is lost and no o_valid is produced.

Test Plan:
- N=4, OWIDTH=20: i_ce=1 continuously, i_data=1,2,3,4 -> one o_valid pulse the cycle after 4 is accepted, o_data=10, o_ovf=0. Next block 5,5,5,5 -> o_data=20, pulses exactly 4 cycles apart.
- N=4: samples -20,-3,7,0 with i_ce low on alternate cycles -> o_data=-16, o_valid only once, o_cnt steps 1,2,3 then 0.
- N=4, OWIDTH=17: four samples of +65535 -> o_data=65535 (saturated), o_ovf=1. Following block of 1,1,1,1 -> o_data=4, o_ovf=0 (sticky cleared).
- N=4: accept 7,7, then i_clr=1 with i_ce=1 and i_data=100 -> o_cnt=0, no pulse. Then 1,1,1,1 -> o_data=4.
- Assert i_reset after 3 samples of a block -> o_valid, o_data, o_ovf, o_cnt all 0 next cycle; no dump. Subsequent 2,2,2,2 -> o_data=8.
- Drive with the adder's random sum stream (a=$random%20, b=$random%4) for 40 cycles -> each o_data equals the reference-model sum of each 4 consecutive valid samples.
